mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLK  in  1  rising-edge clock; nRST  in  1  asynchronous active-low reset.
REQ-002 The block SHALL have these icache-side ports: iREN  in  1  instruction read request; iaddr  in  32  instruction address; iwait  out  1  icache stall; iload  out  32  instruction read data.
REQ-003 The block SHALL have these dcache-side ports: dREN  in  1  data read request; dWEN  in  1  data write request; daddr  in  32  data address; dstore  in  32  write data; dwait  out  1  dcache stall; dload  out  32  data read data.
REQ-004 The block SHALL have these RAM-side ports: ramREN  out  1; ramWEN  out  1; ramaddr  out  32; ramstore  out  32; ramload  in  32; ramstate  in  2  ramstate_t (FREE, BUSY, ACCESS, ERROR).
REQ-005 The block SHALL have this status port: ramerr  out  1  sticky RAM error flag.
REQ-006 The block SHALL have parameter STARVE_MAX, default 4, giving the consecutive dcache completions allowed while iREN is pending.

Function
REQ-007 The block SHALL use states IDLE, IGRANT, DGRANT.
REQ-008 In IDLE, if (dREN|dWEN) and not (iREN and starvecnt==STARVE_MAX), the next state SHALL be DGRANT; else if iREN, IGRANT; else IDLE.
REQ-009 In IDLE, ramREN and ramWEN SHALL be 0, and iwait and dwait SHALL be 1.
REQ-010 In DGRANT: ramREN=dREN, ramWEN=dWEN&~dREN (read wins when both are asserted), ramaddr=daddr, ramstore=dstore.
REQ-011 In IGRANT: ramREN=iREN, ramWEN=0, ramaddr=iaddr, ramstore=0.
REQ-012 Completion SHALL be a cycle in a grant state where ramstate is ACCESS or ERROR.
REQ-013 In the completion cycle only, the granted side's wait SHALL be 0; all other wait outputs SHALL be 1.
REQ-014 iload and dload SHALL equal ramload combinationally (consumers sample only when their wait is 0).
REQ-015 After completion the state SHALL return to IDLE, giving one arbitration bubble per word.
REQ-016 A two-word dcache block SHALL therefore take two grants, which may be separated by an icache grant.
REQ-017 If the granted side drops its request before completion, the next state SHALL be IDLE, RAM strobes SHALL deassert that same cycle, and no wait SHALL go low.
REQ-018 starvecnt (3-bit) SHALL increment, saturating at STARVE_MAX, on each dcache completion where iREN=1 in that cycle.
REQ-019 starvecnt SHALL clear on each icache completion and whenever iREN=0 in IDLE.
REQ-020 On simultaneous requests in IDLE, the dcache SHALL win unless starvecnt==STARVE_MAX.
REQ-021 A grant SHALL be held until completion regardless of new requests from the other side (no preemption).
REQ-022 ramstate=ERROR SHALL complete the transaction as in REQ-012 and set ramerr=1, which holds until reset.
REQ-023 ramstate FREE or BUSY in a grant state SHALL keep the state and strobes unchanged.

Reset
REQ-024 On nRST=0 the block SHALL asynchronously force state=IDLE, starvecnt=0, ramerr=0.
REQ-025 During reset the outputs SHALL be ramREN=0, ramWEN=0, iwait=1, dwait=1.
REQ-026 Reset mid-transaction SHALL abandon the transaction with no completion reported, and strobes SHALL drop in the same cycle.

Structure
REQ-027 ramstate_t and the state enum SHALL live in the shared CPU types package.
REQ-028 STARVE_MAX SHALL be a package constant overridable by the parameter.
REQ-029 The block SHALL be a single module with no sub-modules; the next-state logic, output mux and starvation counter SHALL be separate always blocks.

Verification
REQ-030 iREN=1 alone, ramstate BUSY 2 cycles then ACCESS, ramload=0x8C010004 -> ramREN=1, ramaddr=iaddr; iwait=0 with iload=0x8C010004 in cycle 3 only; IDLE in cycle 4.
REQ-031 iREN and dWEN asserted together, starvecnt=0 -> DGRANT first, ramWEN=1, ramstore=dstore; iwait=1 throughout the dcache transfer.
REQ-032 dREN held continuously with iREN pending, each access 1 cycle -> 4 dcache completions, then IGRANT on the next IDLE; starvecnt=0 after the icache completion.
REQ-033 ramstate=ERROR during DGRANT -> dwait=0 that cycle, ramerr=1 and stays 1 through later accesses until nRST.
REQ-034 dREN dropped in the 2nd BUSY cycle of a DGRANT -> ramREN=0 that cycle, IDLE next cycle, dwait never 0.
REQ-035 nRST pulsed low mid-IGRANT -> ramREN=0 immediately, state=IDLE, starvecnt=0 after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared CPU types for the memory arbiter: RAM handshake state, arbiter
// FSM state and the default starvation limit.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  // Consecutive dcache completions tolerated while the icache is waiting.
  localparam int STARVE_MAX_DEF = 4;
  localparam int STARVE_W       = 3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache/RAM bus seen by the arbiter. The slave modport is the arbiter,
// the master modport is whatever drives the caches and the RAM model.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // icache side
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  // dcache side
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  // RAM side
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-client RAM arbiter: dcache has priority, bounded by a starvation
// counter that forces an icache grant after STARVE_MAX dcache words.
// Every word returns to IDLE, so there is one arbitration bubble per word.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus,
  output logic          ramerr
);

  localparam logic [STARVE_W-1:0] STARVE_MAX_C = STARVE_W'(STARVE_MAX);

  arb_state_t          state_q, state_d;
  logic [STARVE_W-1:0] starvecnt_q, starvecnt_d;
  logic                ramerr_q, ramerr_d;

  logic dreq, ram_done, i_done, d_done, starved;

  // A grant completes only while its requester still holds the request.
  assign dreq     = bus.dREN | bus.dWEN;
  assign ram_done = (bus.ramstate == ACCESS) || (bus.ramstate == ERROR);
  assign i_done   = (state_q == IGRANT) && bus.iREN && ram_done;
  assign d_done   = (state_q == DGRANT) && dreq && ram_done;
  assign starved  = bus.iREN && (starvecnt_q == STARVE_MAX_C);

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: arbitrate in IDLE, hold grants until done or dropped
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (dreq && !starved) state_d = DGRANT;
        else if (bus.iREN)    state_d = IGRANT;
      end
      IGRANT: if (!bus.iREN || i_done) state_d = IDLE;
      DGRANT: if (!dreq || d_done)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output mux: route the granted side to RAM, release its wait on completion
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    unique case (state_q)
      IGRANT: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
        bus.iwait   = ~i_done;
      end
      DGRANT: begin
        bus.ramREN   = bus.dREN;
        bus.ramWEN   = bus.dWEN & ~bus.dREN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.dwait    = ~d_done;
      end
      default: ;
    endcase
  end

  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

  // Starvation counter and sticky error flag
  always_comb begin
    starvecnt_d = starvecnt_q;
    ramerr_d    = ramerr_q;
    if (d_done && bus.iREN && (starvecnt_q != STARVE_MAX_C))
      starvecnt_d = starvecnt_q + STARVE_W'(1);
    if (i_done || ((state_q == IDLE) && !bus.iREN))
      starvecnt_d = '0;
    if ((i_done || d_done) && (bus.ramstate == ERROR))
      ramerr_d = 1'b1;
  end

  // Counter / error registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starvecnt_q <= '0;
      ramerr_q    <= 1'b0;
    end else begin
      starvecnt_q <= starvecnt_d;
      ramerr_q    <= ramerr_d;
    end
  end

  assign ramerr = ramerr_q;

endmodule
